// File: rtl/alu_nibble_seq_ctrl.sv
// Drives one 4-bit 74181 slice across an N-nibble operand, LSB nibble first,
// carrying cn4 of each nibble into cn of the next through a register.
module alu_nibble_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic [3:0]             s,
    input  logic                   m,
    input  logic                   cn_in,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   f,
    output logic                   cn_out,
    output logic                   equal,
    output logic [NIBBLES-1:0]     p_vec,
    output logic [NIBBLES-1:0]     g_vec,
    output logic [3:0]             slice_a,
    output logic [3:0]             slice_b,
    output logic [3:0]             slice_s,
    output logic                   slice_m,
    output logic                   slice_cn,
    input  logic [3:0]             slice_f,
    input  logic                   slice_cn4,
    input  logic                   slice_equal,
    input  logic                   slice_p,
    input  logic                   slice_g
);

    // state | meaning
    // IDLE  | waiting for start; results from the last operation held
    // RUN   | one nibble per enabled edge, index selects the result slot
    // DONE  | results valid, done pulses for this single cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [3:0]      s_q;
    logic            m_q;
    logic            carry;
    logic [IW-1:0]   idx;
    logic            last;

    assign last = (idx == IW'(NIBBLES - 1));

    // Slice inputs come only from registers, so the slice never sees a
    // combinational path from this block's inputs.
    assign slice_a  = a_sh[3:0];
    assign slice_b  = b_sh[3:0];
    assign slice_s  = s_q;
    assign slice_m  = m_q;
    assign slice_cn = carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    begin busy = 1'b1; done = 1'b1; end
            default: begin busy = 1'b0; done = 1'b0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            s_q    <= '0;
            m_q    <= 1'b0;
            carry  <= 1'b1;
            idx    <= '0;
            f      <= '0;
            cn_out <= 1'b1;
            equal  <= 1'b0;
            p_vec  <= '0;
            g_vec  <= '0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        s_q    <= s;
                        m_q    <= m;
                        carry  <= cn_in;
                        idx    <= '0;
                        f      <= '0;
                        cn_out <= 1'b1;
                        equal  <= 1'b1;
                        p_vec  <= '0;
                        g_vec  <= '0;
                    end
                end
                RUN: begin
                    a_sh              <= a_sh >> 4;
                    b_sh              <= b_sh >> 4;
                    f[{idx, 2'b00} +: 4] <= slice_f;
                    carry             <= slice_cn4;
                    equal             <= equal & slice_equal;
                    p_vec[idx]        <= slice_p;
                    g_vec[idx]        <= slice_g;
                    if (last) begin
                        cn_out <= slice_cn4;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_seq_ctrl.sv
// Bench for alu_nibble_seq_ctrl: a behavioural 74181 slice answers the DUT,
// and a whole-width arithmetic model predicts every finished operation.
module tb_alu_nibble_seq_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic          clk = 1'b0;
    logic          rst, ena, start, m, cn_in;
    logic [W-1:0]  a, b;
    logic [3:0]    s;
    logic          busy, done, cn_out, equal;
    logic [W-1:0]  f;
    logic [N-1:0]  p_vec, g_vec;
    logic [3:0]    slice_a, slice_b, slice_s, slice_f;
    logic          slice_m, slice_cn, slice_cn4, slice_equal, slice_p, slice_g;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_nibble_seq_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start),
        .a(a), .b(b), .s(s), .m(m), .cn_in(cn_in),
        .busy(busy), .done(done), .f(f), .cn_out(cn_out), .equal(equal),
        .p_vec(p_vec), .g_vec(g_vec),
        .slice_a(slice_a), .slice_b(slice_b), .slice_s(slice_s),
        .slice_m(slice_m), .slice_cn(slice_cn),
        .slice_f(slice_f), .slice_cn4(slice_cn4), .slice_equal(slice_equal),
        .slice_p(slice_p), .slice_g(slice_g)
    );

    // 74181 slice: arithmetic is X plus Y plus carry, logic is ~(X ^ Y).
    logic [3:0] sx, sy;
    logic [4:0] ssum, sgen;
    assign sx          = slice_a | (slice_b & {4{slice_s[0]}}) | (~slice_b & {4{slice_s[1]}});
    assign sy          = (slice_a & ~slice_b & {4{slice_s[2]}}) | (slice_a & slice_b & {4{slice_s[3]}});
    assign ssum        = {1'b0, sx} + {1'b0, sy} + {4'b0, ~slice_cn};
    assign sgen        = {1'b0, sx} + {1'b0, sy};
    assign slice_f     = slice_m ? ~(sx ^ sy) : ssum[3:0];
    assign slice_cn4   = ~ssum[4];
    assign slice_equal = &slice_f;
    assign slice_p     = ~(&sx);
    assign slice_g     = ~sgen[4];

    typedef struct packed {
        logic [W-1:0] f;
        logic         cn;
        logic         eq;
        logic [N-1:0] p;
        logic [N-1:0] g;
    } res_t;

    typedef struct {
        logic [W-1:0] a, b;
        logic [3:0]   s;
        logic         m, cn;
        logic [W-1:0] ef;
        logic         ecn, eeq;
    } vec_t;

    function automatic res_t ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                    input logic [3:0] rs, input logic rm, input logic rcn);
        res_t         r;
        logic [W-1:0] x, y;
        logic [W:0]   sum;
        logic [3:0]   xn, yn;
        logic [4:0]   gn;
        x     = ra | (rb & {W{rs[0]}}) | (~rb & {W{rs[1]}});
        y     = (ra & ~rb & {W{rs[2]}}) | (ra & rb & {W{rs[3]}});
        sum   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ~rcn};
        r.f   = rm ? ~(x ^ y) : sum[W-1:0];
        r.cn  = ~sum[W];
        r.eq  = &r.f;
        r.p   = '0;
        r.g   = '0;
        for (int k = 0; k < N; k++) begin
            xn     = x[4*k +: 4];
            yn     = y[4*k +: 4];
            gn     = {1'b0, xn} + {1'b0, yn};
            r.p[k] = (xn != 4'hF);
            r.g[k] = ~gn[4];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // gap: 0 = ena held high, 1 = random ena gaps, 2 = ena low 3 cycles after nibble 2
    task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic [3:0] ts, input logic tm, input logic tcn,
                          input int gap, input res_t exp);
        int en_edges = 0;
        int cyc      = 0;
        int held     = 0;
        logic got_done = 1'b0;
        @(negedge clk);
        a = ta; b = tb; s = ts; m = tm; cn_in = tcn; ena = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb; s = ~ts; m = ~tm; cn_in = ~tcn;
        chk({nm, "_busy_run"}, busy, 1);
        while (!got_done && cyc < 100) begin
            if (gap == 1)                      ena = ($urandom_range(3) != 0);
            else if (gap == 2)                 ena = !(en_edges == 2 && held < 3);
            else                               ena = 1'b1;
            if (gap == 2 && !ena) held++;
            @(posedge clk);
            if (ena) en_edges++;
            @(negedge clk);
            cyc++;
            if (done) got_done = 1'b1;
        end
        ena = 1'b1;
        chk({nm, "_done_seen"}, got_done, 1);
        chk({nm, "_latency"}, en_edges, N);
        if (gap == 2) chk({nm, "_cycles"}, cyc, N + 3);
        chk({nm, "_f"}, f, exp.f);
        chk({nm, "_cn_out"}, cn_out, exp.cn);
        chk({nm, "_equal"}, equal, exp.eq);
        chk({nm, "_p_vec"}, p_vec, exp.p);
        chk({nm, "_g_vec"}, g_vec, exp.g);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_busy_after"}, busy, 0);
        chk({nm, "_done_once"}, done, 0);
        chk({nm, "_f_hold"}, f, exp.f);
    endtask

    vec_t tbl[6];
    res_t r;
    int   dcount, bcount;

    initial begin
        tbl[0] = '{16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b1, 16'h2201, 1'b1, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        tbl[2] = '{16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1};
        tbl[3] = '{16'h5A5A, 16'h5A5B, 4'b0110, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0};
        tbl[4] = '{16'hA5A5, 16'h0FF0, 4'b0110, 1'b1, 1'b1, 16'hAA55, 1'b0, 1'b0};
        tbl[5] = '{16'h0000, 16'h1234, 4'b1111, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1};

        rst = 1'b1; ena = 1'b0; start = 1'b0;
        a = '0; b = '0; s = '0; m = 1'b0; cn_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_f", f, 0);
        chk("rst_cn_out", cn_out, 1);
        chk("rst_equal", equal, 0);
        chk("rst_p_vec", p_vec, 0);
        chk("rst_g_vec", g_vec, 0);
        chk("rst_slice_cn", slice_cn, 1);
        rst = 1'b0;

        // start while ena is low must not be taken
        start = 1'b1; a = 16'h1111; b = 16'h2222; s = 4'b1001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ena_low_idle_busy", busy, 0);
        start = 1'b0; ena = 1'b1;

        for (int i = 0; i < 6; i++) begin
            r    = ref_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].m, tbl[i].cn);
            r.f  = tbl[i].ef;
            r.cn = tbl[i].ecn;
            r.eq = tbl[i].eeq;
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].m,
                   tbl[i].cn, 0, r);
        end

        r = ref_op(16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b1);
        run_op("ena_gap", 16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b1, 2, r);

        // start held high: one operation per IDLE visit
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; s = 4'b1001; m = 1'b0; cn_in = 1'b1; start = 1'b1;
        dcount = 0;
        for (int i = 0; i < 3 * (N + 2); i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dcount++;
        end
        start = 1'b0;
        chk("held_start_dones", dcount, 3);
        chk("held_start_f", f, 16'h0003);
        bcount = 0;
        for (int i = 0; i < N + 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) bcount++;
        end
        chk("held_start_no_extra", bcount, 0);

        // start pulsed during RUN and in the DONE cycle is dropped
        @(negedge clk);
        a = 16'h0100; b = 16'h0200; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dcount = 0; bcount = 0;
        for (int i = 0; i < 3 * (N + 2); i++) begin
            start = (i == 1) || done;
            @(posedge clk);
            @(negedge clk);
            if (done) dcount++;
            if (i >= N + 1 && busy) bcount++;
        end
        start = 1'b0;
        chk("busy_start_dones", dcount, 1);
        chk("busy_start_not_queued", bcount, 0);
        chk("busy_start_f", f, 16'h0300);

        // reset in the middle of an add aborts it
        @(negedge clk);
        a = 16'h1234; b = 16'h0FCD; s = 4'b1001; m = 1'b0; cn_in = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_f", f, 0);
        chk("abort_cn_out", cn_out, 1);
        chk("abort_equal", equal, 0);
        chk("abort_pg", {p_vec, g_vec}, 0);
        dcount = 0;
        for (int i = 0; i < N + 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        r = ref_op(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b1);
        chk("abort_model_sum", r.f, 16'h0002);
        run_op("after_abort", 16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b1, 0, r);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic [3:0]   rs;
            logic         rm, rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 4'($urandom);
            rm = 1'($urandom);
            rc = 1'($urandom);
            r  = ref_op(ra, rb, rs, rm, rc);
            run_op($sformatf("rnd%0d", i), ra, rb, rs, rm, rc, i % 2, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
